// File: rtl/aes_pkg.sv
// AES-128 shared definitions: round count, controller state encoding and the GF(2^8)
// byte/column primitives used by both the iterative engine and the flat encrypt path.
package aes_pkg;

   localparam int         NR_AES128 = 10;
   localparam logic [7:0] RCON_INIT = 8'h01;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } fsm_t;

   function automatic logic [7:0] xtime(input logic [7:0] x);
      return {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] acc;
      logic [7:0] sh;
      acc = 8'h00;
      sh  = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) acc = acc ^ sh;
         sh = xtime(sh);
      end
      return acc;
   endfunction

   // Multiplicative inverse as x^254 (square-and-multiply); maps 0 to 0 as AES requires.
   function automatic logic [7:0] gf_inv(input logic [7:0] x);
      logic [7:0] sq;
      logic [7:0] acc;
      sq  = x;
      acc = 8'h01;
      for (int i = 0; i < 7; i++) begin
         sq  = gf_mul(sq, sq);
         acc = gf_mul(acc, sq);
      end
      return acc;
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] b);
      logic [7:0] v;
      v = gf_inv(b);
      return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]}
             ^ 8'h63;
   endfunction

   function automatic logic [31:0] mixcol(input logic [31:0] c);
      logic [7:0] a0, a1, a2, a3;
      {a0, a1, a2, a3} = c;
      return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
              a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
              a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
              xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
   endfunction

endpackage

// File: rtl/aes_round_core.sv
// One combinational AES-128 round: derives the next round key from rk/rcon and applies
// SubBytes, ShiftRows, MixColumns (skipped on the final round) and AddRoundKey to st.
module aes_round_core
   import aes_pkg::*;
(
   input  logic [127:0] st,
   input  logic [127:0] rk,
   input  logic [7:0]   rcon,
   input  logic         is_final,
   output logic [127:0] nxt_st,
   output logic [127:0] nxt_rk
);

   logic [7:0]   sub_b [16];
   logic [7:0]   shf_b [16];
   logic [31:0]  shf_col [4];
   logic [127:0] mix_w;
   logic [31:0]  rot_w, sub_w, tmp_w;
   logic [31:0]  nk0, nk1, nk2, nk3;

   // Key schedule: RotWord/SubWord on the last word, then the running xor chain.
   assign rot_w = {rk[23:0], rk[31:24]};

   for (genvar gi = 0; gi < 4; gi++) begin : g_subw
      assign sub_w[31-8*gi -: 8] = sbox(rot_w[31-8*gi -: 8]);
   end

   assign tmp_w  = sub_w ^ {rcon, 24'h000000};
   assign nk0    = rk[127:96] ^ tmp_w;
   assign nk1    = nk0 ^ rk[95:64];
   assign nk2    = nk1 ^ rk[63:32];
   assign nk3    = nk2 ^ rk[31:0];
   assign nxt_rk = {nk0, nk1, nk2, nk3};

   // Byte gi sits at column gi/4, row gi%4; row r rotates left by r columns.
   for (genvar gi = 0; gi < 16; gi++) begin : g_sub
      assign sub_b[gi] = sbox(st[127-8*gi -: 8]);
      assign shf_b[gi] = sub_b[4*(((gi/4) + (gi%4)) % 4) + (gi%4)];
   end

   for (genvar gi = 0; gi < 4; gi++) begin : g_col
      assign shf_col[gi] = {shf_b[4*gi], shf_b[4*gi+1], shf_b[4*gi+2], shf_b[4*gi+3]};
      assign mix_w[127-32*gi -: 32] = is_final ? shf_col[gi] : mixcol(shf_col[gi]);
   end

   assign nxt_st = mix_w ^ nxt_rk;

endmodule

// File: rtl/aes128_iter_ctrl.sv
// Iterative AES-128 encryption sequencer: one round per cycle with on-the-fly key
// expansion, valid/ready on both the job input and the ciphertext output.
module aes128_iter_ctrl #(
   parameter int         NR        = aes_pkg::NR_AES128,
   parameter logic [7:0] RCON_INIT = aes_pkg::RCON_INIT
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] data_in,
   input  logic [127:0] key,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] data_out,
   output logic         busy
);
   import aes_pkg::*;

   if (NR != NR_AES128) begin : g_bad_nr
      $error("aes128_iter_ctrl supports only NR = 10 (AES-128)");
   end

   localparam logic [3:0] LAST_RND = 4'(NR);

   fsm_t         state_q;
   logic [127:0] st_q;
   logic [127:0] rk_q;
   logic [3:0]   rnd_q;
   logic [7:0]   rcon_q;
   logic [127:0] nxt_st;
   logic [127:0] nxt_rk;
   logic         last_rnd;

   assign last_rnd = (rnd_q == LAST_RND);

   aes_round_core u_round (
      .st       (st_q),
      .rk       (rk_q),
      .rcon     (rcon_q),
      .is_final (last_rnd),
      .nxt_st   (nxt_st),
      .nxt_rk   (nxt_rk)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         data_out  <= '0;
         st_q      <= '0;
         rk_q      <= '0;
         rnd_q     <= '0;
         rcon_q    <= RCON_INIT;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (in_valid) begin
                  st_q     <= data_in ^ key;
                  rk_q     <= key;
                  rnd_q    <= 4'd1;
                  rcon_q   <= RCON_INIT;
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
                  state_q  <= ST_RUN;
               end
            end
            ST_RUN: begin
               st_q   <= nxt_st;
               rk_q   <= nxt_rk;
               rcon_q <= xtime(rcon_q);
               // The round counter parks at NR so it never leaves the legal range.
               if (last_rnd) begin
                  data_out  <= nxt_st;
                  out_valid <= 1'b1;
                  state_q   <= ST_DONE;
               end else begin
                  rnd_q <= rnd_q + 4'd1;
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  busy      <= 1'b0;
                  state_q   <= ST_IDLE;
               end
            end
            default: begin
               state_q   <= ST_IDLE;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_aes128_iter_ctrl.sv
// Bench for aes128_iter_ctrl: a textbook AES-128 reference plus a job-level timing model,
// compared against the DUT outputs every cycle, with FIPS-197 literals pinning the model.
module tb_aes128_iter_ctrl;

   localparam logic [127:0] APPB_PT  = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] APPB_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] APPB_CT  = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] C1_PT    = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] C1_KEY   = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] C1_CT    = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [127:0] data_in = '0;
   logic [127:0] key = '0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [127:0] data_out;
   logic         busy;

   int n_checks = 0;
   int n_fail   = 0;
   bit chk_en   = 1'b0;

   aes128_iter_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .data_in   (data_in),
      .key       (key),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .data_out  (data_out),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- reference AES-128 ----------------
   logic [7:0] sb [256];

   function automatic logic [7:0] mul2(input logic [7:0] x);
      return {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
   endfunction

   // S-box generated by walking the multiplicative group with generator 3 and its inverse.
   task automatic build_sbox();
      logic [7:0] p, q, x;
      p = 8'h01;
      q = 8'h01;
      do begin
         p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1B : 8'h00);
         q = q ^ {q[6:0], 1'b0};
         q = q ^ {q[5:0], 2'b00};
         q = q ^ {q[3:0], 4'h0};
         if (q[7]) q = q ^ 8'h09;
         x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
         sb[p] = x ^ 8'h63;
      end while (p != 8'h01);
      sb[0] = 8'h63;
   endtask

   function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] k);
      logic [31:0]  w [44];
      logic [7:0]   s [16];
      logic [7:0]   t [16];
      logic [31:0]  tmp;
      logic [7:0]   rc, a0, a1, a2, a3;
      logic [127:0] res;
      rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         tmp = w[i-1];
         if (i % 4 == 0) begin
            tmp = {sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]], sb[tmp[31:24]]} ^ {rc, 24'h0};
            rc  = mul2(rc);
         end
         w[i] = w[i-4] ^ tmp;
      end
      for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
      for (int r = 1; r <= 10; r++) begin
         for (int i = 0; i < 16; i++) t[i] = sb[s[i]];
         for (int c = 0; c < 4; c++)
            for (int row = 0; row < 4; row++)
               s[4*c+row] = t[4*((c+row)%4)+row];
         if (r < 10) begin
            for (int c = 0; c < 4; c++) begin
               a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
               s[4*c]   = mul2(a0) ^ mul2(a1) ^ a1 ^ a2 ^ a3;
               s[4*c+1] = a0 ^ mul2(a1) ^ mul2(a2) ^ a2 ^ a3;
               s[4*c+2] = a0 ^ a1 ^ mul2(a2) ^ mul2(a3) ^ a3;
               s[4*c+3] = mul2(a0) ^ a0 ^ a1 ^ a2 ^ mul2(a3);
            end
         end
         for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*r + i/4][31-8*(i%4) -: 8];
      end
      for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
      return res;
   endfunction

   // ---------------- check helpers ----------------
   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp);
      end
   endtask

   // ---------------- job-level timing model ----------------
   // m_mode: 0 waiting for a job, 1 computing (10 cycles), 2 result offered.
   int           m_mode = 0;
   int           m_cnt  = 0;
   logic [127:0] m_res  = '0;
   logic [127:0] m_data = '0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_mode = 0;
         m_cnt  = 0;
         m_data = '0;
      end else begin
         case (m_mode)
            0: if (in_valid) begin
                  m_res  = aes_ref(data_in, key);
                  m_cnt  = 0;
                  m_mode = 1;
               end
            1: begin
                  m_cnt++;
                  if (m_cnt == 10) begin
                     m_data = m_res;
                     m_mode = 2;
                  end
               end
            default: if (out_ready) m_mode = 0;
         endcase
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("in_ready", 128'(in_ready), 128'(m_mode == 0));
         check("busy", 128'(busy), 128'(m_mode != 0));
         check("out_valid", 128'(out_valid), 128'(m_mode == 2));
         check("data_out", data_out, m_data);
      end
   end

   // ---------------- handshake monitor ----------------
   int cyc = 0;
   int acc_cyc = 0;
   int hs_cnt = 0;
   int acc_q[$];
   int hs_q[$];

   always @(posedge clk) begin
      cyc++;
      if (!rst && in_valid && in_ready) begin
         acc_cyc = cyc;
         acc_q.push_back(cyc);
      end
      if (!rst && out_valid && out_ready) begin
         hs_cnt++;
         hs_q.push_back(cyc);
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic wait_ov(input int limit, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < limit && !ok; i++) begin
         @(negedge clk);
         if (out_valid === 1'b1) ok = 1'b1;
      end
   endtask

   task automatic send(input logic [127:0] pt, input logic [127:0] k);
      tick();
      in_valid = 1'b1;
      data_in  = pt;
      key      = k;
      tick();
      in_valid = 1'b0;
      data_in  = ~pt;
      key      = ~k;
   endtask

   // ---------------- directed stimulus ----------------
   initial begin
      bit ok;
      int hs0, na, nh, n_jobs;

      build_sbox();
      check("model_appB", aes_ref(APPB_PT, APPB_KEY), APPB_CT);
      check("model_C1", aes_ref(C1_PT, C1_KEY), C1_CT);

      #1 rst = 1'b1;
      #1 chk_en = 1'b1;
      #1;
      check("reset_in_ready", 128'(in_ready), 128'(1));
      check("reset_out_valid", 128'(out_valid), 128'(0));
      check("reset_busy", 128'(busy), 128'(0));
      check("reset_data_out", data_out, 128'h0);
      tick();
      tick();
      rst = 1'b0;
      $display("reset released");

      // out_ready outside DONE must be harmless
      tick();
      out_ready = 1'b1;
      tick();
      tick();
      out_ready = 1'b0;

      // App.B with 7 cycles of backpressure
      send(APPB_PT, APPB_KEY);
      wait_ov(20, ok);
      check_int("appB_timeout", int'(ok), 1);
      check_int("appB_latency", cyc - acc_cyc, 10);
      check("appB_result", data_out, APPB_CT);
      hs0 = hs_cnt;
      for (int i = 0; i < 7; i++) begin
         tick();
         @(negedge clk);
         check("bp_data_stable", data_out, APPB_CT);
         check("bp_in_ready_low", 128'(in_ready), 128'(0));
      end
      tick();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      @(negedge clk);
      check_int("bp_single_handshake", hs_cnt - hs0, 1);
      check("bp_released_ov", 128'(out_valid), 128'(0));
      $display("job appB backpressure: data_out=%h", data_out);

      // C.1 with a second job pulsed while busy
      hs0 = hs_cnt;
      na  = acc_q.size();
      tick();
      out_ready = 1'b1;
      send(C1_PT, C1_KEY);
      tick();
      in_valid = 1'b1;
      data_in  = APPB_PT;
      key      = APPB_KEY;
      tick();
      in_valid = 1'b0;
      wait_ov(20, ok);
      check_int("c1_timeout", int'(ok), 1);
      check("c1_result", data_out, C1_CT);
      repeat (25) tick();
      check_int("drop_handshakes", hs_cnt - hs0, 1);
      check_int("drop_accepts", acc_q.size() - na, 1);
      check_int("c1_done_one_cycle", hs_q[hs_q.size()-1] - acc_q[acc_q.size()-1], 11);
      $display("job C1 busy-drop: data_out=%h", data_out);

      // reset in the middle of round 5
      out_ready = 1'b0;
      send(APPB_PT, APPB_KEY);
      repeat (4) tick();
      rst = 1'b1;
      #1;
      check("midrst_out_valid", 128'(out_valid), 128'(0));
      check("midrst_data_out", data_out, 128'h0);
      check("midrst_in_ready", 128'(in_ready), 128'(1));
      check("midrst_busy", 128'(busy), 128'(0));
      tick();
      rst = 1'b0;
      out_ready = 1'b1;
      send(APPB_PT, APPB_KEY);
      wait_ov(20, ok);
      check_int("after_rst_timeout", int'(ok), 1);
      check("after_rst_result", data_out, APPB_CT);
      $display("job appB after reset: data_out=%h", data_out);
      repeat (3) tick();

      // back-to-back jobs with both handshakes held open
      na = acc_q.size();
      nh = hs_q.size();
      in_valid = 1'b1;
      data_in  = C1_PT;
      key      = C1_KEY;
      repeat (40) tick();
      in_valid = 1'b0;
      repeat (15) tick();
      n_jobs = acc_q.size() - na;
      check_int("b2b_jobs_min", int'(n_jobs >= 3), 1);
      check_int("b2b_pairs", hs_q.size() - nh, n_jobs);
      for (int i = 0; i < n_jobs && nh + i < hs_q.size(); i++) begin
         check_int("b2b_acc_to_hs", hs_q[nh+i] - acc_q[na+i], 11);
         if (i > 0) check_int("b2b_period", acc_q[na+i] - acc_q[na+i-1], 12);
         $display("b2b job %0d: accept cycle %0d, handshake cycle %0d",
                  i, acc_q[na+i], hs_q[nh+i]);
      end
      check("b2b_last_result", data_out, C1_CT);

      chk_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
